// File: rtl/async_ram1_pkg.sv
// Shared constants, types and mode decode for the 8 x 16 async-read RAM.
package async_ram1_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    CONFLICT
  } ram_mode_t;

  function automatic ram_mode_t decode_mode(
    input logic we,
    input logic en
  );
    ram_mode_t m;
    unique case ({we, en})
      2'b10:   m = WRITE;
      2'b01:   m = READ;
      2'b11:   m = CONFLICT;
      default: m = IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/async_ram1_bus_drv.sv
// Tri-state driver for the shared data bus.
// Keeps the only high-impedance assignment out of the storage logic.
module async_ram1_bus_drv
  import async_ram1_pkg::*;
(
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] din,
  inout  wire  [DATA_WIDTH-1:0] data
);

  assign data = oe ? din : 'z;

endmodule

// File: rtl/asynchronous_ram_1.sv
// 8 x 16 RAM: clocked write, combinational read on a shared bidir bus.
// ASYNC_RAM1_CONFLICT_FLAG_EN adds a sticky conflict_out flag.
module asynchronous_ram_1
  import async_ram1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_in,
  input  logic                  enable_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  inout  wire  [DATA_WIDTH-1:0] data
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
  ,
  output logic                  conflict_out
`endif
);

  data_t     mem [DEPTH];
  ram_mode_t mode;
  logic      oe;
  data_t     rd_data;

  assign mode    = decode_mode(we_in, enable_in);
  assign oe      = (mode == READ);
  assign rd_data = mem[addr_in];

  // Reset wins over a coincident write; CONFLICT never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mode == WRITE) begin
      mem[addr_in] <= data;
    end
  end

`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_out <= 1'b0;
    end else if (mode == CONFLICT) begin
      conflict_out <= 1'b1;
    end
  end
`endif

  async_ram1_bus_drv u_bus_drv (
    .oe   (oe),
    .din  (rd_data),
    .data (data)
  );

endmodule

// File: tb/tb_asynchronous_ram_1.sv
// Directed self-checking bench for asynchronous_ram_1.
module tb_asynchronous_ram_1;

  logic        clk;
  logic        rst;
  logic        we_in;
  logic        enable_in;
  logic [2:0]  addr_in;
  wire  [15:0] data;
  logic        host_oe;
  logic [15:0] host_val;
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
  logic        conflict_out;
`endif

  int n_vec;
  int n_miss;

  assign data = host_oe ? host_val : 'z;

  asynchronous_ram_1 dut (
    .clk       (clk),
    .rst       (rst),
    .we_in     (we_in),
    .enable_in (enable_in),
    .addr_in   (addr_in),
    .data      (data)
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
    ,
    .conflict_out (conflict_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    n_vec++;
    assert (data === exp) else begin
      n_miss++;
      $error("FAIL %s: bus=%h expected=%h", tag, data, exp);
    end
  endtask

`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
  task automatic chk_flag(input string tag, input logic exp);
    n_vec++;
    assert (conflict_out === exp) else begin
      n_miss++;
      $error("FAIL %s: conflict_out=%b expected=%b", tag, conflict_out, exp);
    end
  endtask
`endif

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    we_in     = 1'b0;
    enable_in = 1'b0;
    addr_in   = '0;
    host_oe   = 1'b0;
    host_val  = '0;

    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
    #1 chk_flag("flag_after_reset", 1'b0);
`endif

    // reset contents
    enable_in = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr_in = 3'(a);
      #1 chk($sformatf("reset_rd%0d", a), 16'h0000);
    end

    // write a -> mem[a]
    @(negedge clk);
    enable_in = 1'b0;
    we_in     = 1'b1;
    host_oe   = 1'b1;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      addr_in  = 3'(a);
      host_val = 16'(a);
      @(posedge clk);
    end
    @(negedge clk);
    we_in     = 1'b0;
    host_oe   = 1'b0;
    enable_in = 1'b1;
    for (int b = 0; b < 8; b++) begin
      addr_in = 3'(b);
      #1 chk($sformatf("rd%0d", b), 16'(b));
    end

    // write BEEF to 5, then address change mid-read
    @(negedge clk);
    enable_in = 1'b0;
    we_in     = 1'b1;
    host_oe   = 1'b1;
    addr_in   = 3'd5;
    host_val  = 16'hBEEF;
    @(posedge clk);
    #1;
    we_in     = 1'b0;
    host_oe   = 1'b0;
    enable_in = 1'b1;
    #1 chk("raw_beef", 16'hBEEF);
    #1 addr_in = 3'd2;
    #1 chk("addr_switch", 16'h0002);

    // idle: bus carries host value only, no write on edge
    @(negedge clk);
    enable_in = 1'b0;
    addr_in   = 3'd5;
    host_oe   = 1'b1;
    host_val  = 16'h1234;
    #1 chk("idle_bus", 16'h1234);
    @(negedge clk);
    host_oe   = 1'b0;
    enable_in = 1'b1;
    #1 chk("idle_nowrite", 16'hBEEF);

    // write: RAM stays off the bus
    @(negedge clk);
    enable_in = 1'b0;
    we_in     = 1'b1;
    addr_in   = 3'd6;
    host_oe   = 1'b1;
    host_val  = 16'h1234;
    #1 chk("write_bus", 16'h1234);
    @(negedge clk);
    we_in     = 1'b0;
    host_oe   = 1'b0;
    enable_in = 1'b1;
    #1 chk("write_rd6", 16'h1234);

    // conflict: no write, no drive
    @(negedge clk);
    we_in     = 1'b1;
    enable_in = 1'b1;
    addr_in   = 3'd3;
    host_oe   = 1'b1;
    host_val  = 16'hAAAA;
    #1 chk("conflict_bus", 16'hAAAA);
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
    chk_flag("flag_pre_conflict", 1'b0);
`endif
    @(negedge clk);
    we_in   = 1'b0;
    host_oe = 1'b0;
    #1 chk("conflict_nowrite", 16'h0003);
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
    chk_flag("flag_set", 1'b1);
    @(negedge clk);
    enable_in = 1'b0;
    #1 chk_flag("flag_sticky", 1'b1);
`endif

    // reset beats coincident write
    @(negedge clk);
    rst       = 1'b1;
    enable_in = 1'b0;
    we_in     = 1'b1;
    addr_in   = 3'd7;
    host_oe   = 1'b1;
    host_val  = 16'hFFFF;
    @(negedge clk);
    rst       = 1'b0;
    we_in     = 1'b0;
    host_oe   = 1'b0;
    enable_in = 1'b1;
    #1 chk("rst_vs_wr7", 16'h0000);
    addr_in = 3'd5;
    #1 chk("rst_clr5", 16'h0000);
`ifdef ASYNC_RAM1_CONFLICT_FLAG_EN
    chk_flag("flag_cleared", 1'b0);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
